// File: rtl/pulse_train_gen_if.sv
// rtl/pulse_train_gen_if.sv - control and waveform bundle for the pulse train generator
interface pulse_train_gen_if #(
   parameter int CNT_W = 8,
   parameter int NUM_W = 8
);
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] high_len;
   logic [CNT_W-1:0] low_len;
   logic [NUM_W-1:0] pulse_num;
   logic             data_out;
   logic             busy;
   logic             done;
   logic             rise_mark;
   logic             fall_mark;

   modport master (
      output start, abort, high_len, low_len, pulse_num,
      input  data_out, busy, done, rise_mark, fall_mark
   );

   modport slave (
      input  start, abort, high_len, low_len, pulse_num,
      output data_out, busy, done, rise_mark, fall_mark
   );
endinterface

// File: rtl/pulse_train_gen.sv
// rtl/pulse_train_gen.sv - programmable N-pulse serial train with per-edge marker strobes
module pulse_train_gen #(
   parameter int CNT_W = 8,
   parameter int NUM_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   pulse_train_gen_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [NUM_W-1:0] NUM_ONE = 1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic [CNT_W-1:0] low_q, low_d;
   logic [NUM_W-1:0] rem_q, rem_d;
   logic             data_q, data_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   logic             accept;
   logic             empty_train;
   logic             phase_end;
   logic             last_pulse;
   logic [CNT_W-1:0] high_eff;
   logic [CNT_W-1:0] low_eff;

   // Abort has priority over start even while idle.
   assign accept      = (state_q == IDLE) && bus.start && !bus.abort;
   assign empty_train = (bus.pulse_num == '0);
   assign high_eff    = (bus.high_len == '0) ? CNT_ONE : bus.high_len;
   assign low_eff     = (bus.low_len == '0) ? CNT_ONE : bus.low_len;
   assign phase_end   = (cnt_q == '0);
   assign last_pulse  = (rem_q <= NUM_ONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         high_q  <= '0;
         low_q   <= '0;
         rem_q   <= '0;
         data_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         high_q  <= high_d;
         low_q   <= low_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      high_d  = high_q;
      low_d   = low_q;
      rem_d   = rem_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               high_d = high_eff;
               low_d  = low_eff;
               rem_d  = bus.pulse_num;
               if (!empty_train) begin
                  state_d = HIGH;
                  cnt_d   = high_eff - CNT_ONE;
               end
            end
         end
         HIGH: begin
            if (bus.abort) begin
               state_d = IDLE;
               cnt_d   = '0;
               rem_d   = '0;
            end else if (phase_end) begin
               state_d = LOW;
               cnt_d   = low_q - CNT_ONE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         LOW: begin
            if (bus.abort) begin
               state_d = IDLE;
               cnt_d   = '0;
               rem_d   = '0;
            end else if (phase_end) begin
               if (!last_pulse) begin
                  state_d = HIGH;
                  cnt_d   = high_q - CNT_ONE;
                  rem_d   = rem_q - NUM_ONE;
               end else begin
                  state_d = IDLE;
                  rem_d   = '0;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            rem_d   = '0;
         end
      endcase
   end

   // Outputs are decoded one cycle ahead so every port comes straight from a flop.
   always_comb begin
      data_d = 1'b0;
      busy_d = 1'b0;
      done_d = 1'b0;
      rise_d = 1'b0;
      fall_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (empty_train) begin
                  done_d = 1'b1;
               end else begin
                  data_d = 1'b1;
                  busy_d = 1'b1;
                  rise_d = 1'b1;
               end
            end
         end
         HIGH: begin
            if (bus.abort) begin
               fall_d = 1'b1;
            end else if (phase_end) begin
               busy_d = 1'b1;
               fall_d = 1'b1;
            end else begin
               data_d = 1'b1;
               busy_d = 1'b1;
            end
         end
         LOW: begin
            if (bus.abort) begin
               busy_d = 1'b0;
            end else if (phase_end) begin
               if (!last_pulse) begin
                  data_d = 1'b1;
                  busy_d = 1'b1;
                  rise_d = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end else begin
               busy_d = 1'b1;
            end
         end
         default: begin
            data_d = 1'b0;
         end
      endcase
   end

   assign bus.data_out  = data_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.rise_mark = rise_q;
   assign bus.fall_mark = fall_q;

   a_marks_exclusive: assert property (@(posedge clk) disable iff (rst) !(rise_q && fall_q));
   a_done_not_busy:   assert property (@(posedge clk) disable iff (rst) done_q |-> !busy_q);
endmodule
